// File: rtl/sig_delay_pkg.sv
// Shared constants and FSM encoding for the sig_delay audio delay line.
package sig_delay_pkg;
   localparam int DEF_ADDRESS_WIDTH = 9;
   localparam int DEF_DATA_WIDTH    = 8;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/sig_delay_if.sv
// Sample stream bundle between the mic source (master) and the delay line (slave).
interface sig_delay_if
   import sig_delay_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH
);
   // en is a one-cycle strobe with no back-pressure: each cycle it is high the
   // slave consumes mic_signal/offset. delay_valid qualifies delayed_signal,
   // which only changes on the edge closing an en cycle.
   logic                     en;
   logic [ADDRESS_WIDTH-1:0] offset;
   logic [DATA_WIDTH-1:0]    mic_signal;
   logic [DATA_WIDTH-1:0]    delayed_signal;
   logic                     delay_valid;

   modport master (
      output en, offset, mic_signal,
      input  delayed_signal, delay_valid
   );

   modport slave (
      input  en, offset, mic_signal,
      output delayed_signal, delay_valid
   );
endinterface

// File: rtl/sig_delay_ram2ports.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A same-address read returns the old word; callers bypass when needed.
module ram2ports #(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0]    wr_data_i,
   input  logic                     rd_en_i,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0]    rd_data_o
);
   logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sig_delay.sv
// Programmable sample delay line: writes every strobed mic sample into a ring
// buffer and reads it back offset strobes later once the buffer has filled.
module sig_delay
   import sig_delay_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   sig_delay_if.slave    bus,
   output state_e        dbg_state_o
);
   logic [0:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
   logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic                     bypass_q;
   logic [DATA_WIDTH-1:0]    bypass_data_q;
   logic [DATA_WIDTH-1:0]    ram_rd_data;

   assign rd_addr = wr_addr_q - offset_q;

   ram2ports #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_ram (
      .clk      (clk),
      .wr_en_i  (bus.en),
      .wr_addr_i(wr_addr_q),
      .wr_data_i(bus.mic_signal),
      .rd_en_i  (bus.en),
      .rd_addr_i(rd_addr),
      .rd_data_o(ram_rd_data)
   );

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      offset_d   = offset_q;
      fill_cnt_d = fill_cnt_q;
      if (bus.en) begin
         wr_addr_d = wr_addr_q + ADDRESS_WIDTH'(1);
         // A new offset invalidates everything buffered so far: refill from scratch.
         if (bus.offset != offset_q) begin
            offset_d   = bus.offset;
            fill_cnt_d = '0;
            state_d    = ST_FILL;
         end else if (state_q == ST_FILL) begin
            if (fill_cnt_q == offset_q) begin
               state_d = ST_RUN;
            end else if (fill_cnt_q != '1) begin
               fill_cnt_d = fill_cnt_q + ADDRESS_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_FILL;
         wr_addr_q     <= '0;
         offset_q      <= '0;
         fill_cnt_q    <= '0;
         bypass_q      <= 1'b0;
         bypass_data_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         offset_q   <= offset_d;
         fill_cnt_q <= fill_cnt_d;
         if (bus.en) begin
            bypass_q      <= (offset_q == '0);
            bypass_data_q <= bus.mic_signal;
         end
      end
   end

   // Output is masked by the registered state, so reset and refill zero it at once.
   assign bus.delay_valid    = (state_q == ST_RUN);
   assign bus.delayed_signal = (state_q == ST_RUN)
                               ? (bypass_q ? bypass_data_q : ram_rd_data)
                               : '0;
   assign dbg_state_o        = state_e'(state_q);
endmodule
